// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// Requester indices: 0 fetch, 1 data, 2 ext.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_DATA  = 1;
  localparam int unsigned REQ_EXT   = 2;
  localparam int unsigned NUM_REQ   = 3;

  typedef logic [1:0]         req_idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  function automatic req_vec_t idx_to_onehot(req_idx_t idx);
    req_vec_t oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (idx == req_idx_t'(i));
    end
    return oh;
  endfunction

  // Wraps NUM_REQ-1 back to fetch so the round-robin pointer stays in range.
  function automatic req_idx_t next_idx(req_idx_t idx);
    return (idx == req_idx_t'(NUM_REQ - 1)) ? req_idx_t'(0) : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshake plus external memory bus signals of mem_bus_arbiter.
// master: the arbiter side; slave: requesters and memory.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic [mem_arb_pkg::NUM_REQ-1:0]             req_i;
  logic [mem_arb_pkg::NUM_REQ-1:0]             we_i;
  logic [mem_arb_pkg::NUM_REQ-1:0][ADDR_W-1:0] addr_i;
  logic [mem_arb_pkg::NUM_REQ-1:0][DATA_W-1:0] wdata_i;
  logic [mem_arb_pkg::NUM_REQ-1:0]             gnt_o;
  logic [mem_arb_pkg::NUM_REQ-1:0]             done_o;
  logic [DATA_W-1:0]                           rdata_o;
  logic                                        busy_o;
  logic [ADDR_W-1:0]                           mem_addr;
  logic [DATA_W-1:0]                           mem_wdata;
  logic [DATA_W-1:0]                           mem_rdata;
  logic                                        mem_oe;
  logic                                        mem_we;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata,
    output gnt_o, done_o, rdata_o, busy_o, mem_addr, mem_wdata, mem_oe, mem_we
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, mem_rdata,
    input  gnt_o, done_o, rdata_o, busy_o, mem_addr, mem_wdata, mem_oe, mem_we
  );

endinterface

// File: rtl/arb_select.sv
// Combinational winner pick for mem_bus_arbiter. MEM_ARB_ROUND_ROBIN_EN selects
// round-robin from ptr_i; otherwise fixed priority ext > data > fetch.
module arb_select
  import mem_arb_pkg::*;
(
  input  req_vec_t req_i,
  input  req_idx_t ptr_i,
  output req_vec_t gnt_o,
  output req_idx_t idx_o,
  output logic     valid_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_idx_t cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = ptr_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
      cand = next_idx(cand);
    end
    gnt_o = valid_o ? idx_to_onehot(idx_o) : req_vec_t'(0);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    valid_o = |req_i;
    if (req_i[REQ_EXT]) begin
      idx_o = req_idx_t'(REQ_EXT);
    end else if (req_i[REQ_DATA]) begin
      idx_o = req_idx_t'(REQ_DATA);
    end else begin
      idx_o = req_idx_t'(REQ_FETCH);
    end
    gnt_o = valid_o ? idx_to_onehot(idx_o) : req_vec_t'(0);
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter/sequencer for the shared external memory bus: one access per grant with
// WAIT_STATES extra cycles. Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);

  localparam int unsigned CntW = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

  arb_state_t        state_q, state_d;
  req_idx_t          winner_q, winner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  req_vec_t          gnt_q, gnt_d;
  req_vec_t          done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;

  req_vec_t req_masked;
  req_vec_t sel_gnt;
  req_idx_t sel_idx;
  req_idx_t ptr;
  logic     sel_valid;
  logic     start;

  // The requester just served still holds req during DONE; keep it out of the pick.
  assign req_masked = bus.req_i &
                      ~((state_q == DONE) ? idx_to_onehot(winner_q) : req_vec_t'(0));
  assign start      = sel_valid && (state_q != ACCESS);

  arb_select u_arb_select (
    .req_i   (req_masked),
    .ptr_i   (ptr),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_idx_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (start) begin
      ptr_d = next_idx(sel_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= req_idx_t'(REQ_FETCH);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = req_idx_t'(REQ_FETCH);
`endif

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    mem_oe_d = mem_oe_q;

    unique case (state_q)
      IDLE: ;
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          done_d   = idx_to_onehot(winner_q);
          mem_oe_d = 1'b0;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        mem_oe_d = 1'b0;
      end
    endcase

    // A new winner overrides the IDLE/DONE defaults, giving back-to-back accesses.
    if (start) begin
      state_d  = ACCESS;
      winner_d = sel_idx;
      we_d     = bus.we_i[sel_idx];
      addr_d   = bus.addr_i[sel_idx];
      wdata_d  = bus.wdata_i[sel_idx];
      cnt_d    = CntW'(WAIT_STATES);
      gnt_d    = sel_gnt;
      mem_oe_d = we_d;
    end

    // Write strobe only in the final ACCESS cycle.
    mem_we_d = (state_d == ACCESS) && we_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      mem_oe_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      mem_oe_q <= mem_oe_d;
      mem_we_q <= mem_we_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.done_o    = done_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.mem_we    = mem_we_q;

endmodule
